// File: rtl/ddr3_timing_pkg.sv
// Shared DDR3 timing constants (200 MHz controller clock) and refresh FSM state type.
package ddr3_timing_pkg;

  localparam int unsigned TREFI_CYCLES_200M = 1560;
  localparam int unsigned TRFC_CYCLES_200M  = 32;
  localparam int unsigned DDR3_MAX_POSTPONE = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RFC
  } ref_state_e;

endpackage

// File: rtl/refresh_scheduler_if.sv
// Refresh request/acknowledge bus between the refresh scheduler and the command state machine.
interface refresh_scheduler_if #(
  parameter int unsigned OW = 4
);

  logic          ref_req;
  logic          ref_ack;
  logic          ref_busy;
  logic          urgent;
  logic          overflow;
  logic [OW-1:0] owed;

  // master: the scheduler raising requests; slave: the command state machine serving them
  modport master (
    output ref_req, ref_busy, urgent, overflow, owed,
    input  ref_ack
  );

  modport slave (
    input  ref_req, ref_busy, urgent, overflow, owed,
    output ref_ack
  );

endinterface

// File: rtl/refresh_interval_timer.sv
// tREFI interval counter; emits a one-cycle tick at the last count of each interval.
module refresh_interval_timer #(
  parameter int unsigned TREFI_CYCLES = 1560
) (
  input  logic clk,
  input  logic RESET_SM_button,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned    CW   = $clog2(TREFI_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(TREFI_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge RESET_SM_button) begin
    if (RESET_SM_button) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/refresh_scheduler.sv
// DDR3 refresh scheduler: accumulates tREFI credits, requests refreshes via req/ack,
// and holds a tRFC busy window after each accepted refresh.
module refresh_scheduler
  import ddr3_timing_pkg::*;
#(
  parameter int unsigned TREFI_CYCLES  = TREFI_CYCLES_200M,
  parameter int unsigned TRFC_CYCLES   = TRFC_CYCLES_200M,
  parameter int unsigned MAX_POSTPONE  = DDR3_MAX_POSTPONE,
  parameter int unsigned URGENT_THRESH = 6
) (
  input  logic                clk,
  input  logic                RESET_SM_button,
  input  logic                enable,
  refresh_scheduler_if.master ref_bus
);

  localparam int unsigned   OW       = $clog2(MAX_POSTPONE + 1);
  localparam int unsigned   RW       = (TRFC_CYCLES > 1) ? $clog2(TRFC_CYCLES) : 1;
  localparam logic [OW-1:0] OWED_MAX = OW'(MAX_POSTPONE);
  localparam logic [OW-1:0] URG_LVL  = OW'(URGENT_THRESH);
  localparam logic [RW-1:0] RFC_LOAD = RW'(TRFC_CYCLES - 1);

  ref_state_e    state_q;
  logic [OW-1:0] owed_q, owed_d;
  logic [RW-1:0] rfc_q;
  logic          overflow_q, overflow_d;
  logic          ref_req_q, ref_busy_q, urgent_q;
  logic          tick, accept;

  refresh_interval_timer #(
    .TREFI_CYCLES(TREFI_CYCLES)
  ) u_timer (
    .clk             (clk),
    .RESET_SM_button (RESET_SM_button),
    .enable_i        (enable),
    .tick_o          (tick)
  );

  assign accept = (state_q == REQ) && ref_bus.ref_ack;

  // A coincident tick and accepted ack cancel; saturation at MAX_POSTPONE flags overflow.
  always_comb begin
    owed_d     = owed_q;
    overflow_d = overflow_q;
    case ({tick, accept})
      2'b10: begin
        if (owed_q == OWED_MAX) overflow_d = 1'b1;
        else                    owed_d     = owed_q + OW'(1);
      end
      2'b01: begin
        if (owed_q != '0) owed_d = owed_q - OW'(1);
      end
      default: ;
    endcase
  end

  // Transitions look at owed_d so ref_req follows a tick by exactly one cycle.
  always_ff @(posedge clk or posedge RESET_SM_button) begin
    if (RESET_SM_button) begin
      state_q    <= IDLE;
      owed_q     <= '0;
      rfc_q      <= '0;
      overflow_q <= 1'b0;
      ref_req_q  <= 1'b0;
      ref_busy_q <= 1'b0;
      urgent_q   <= 1'b0;
    end else begin
      owed_q     <= owed_d;
      overflow_q <= overflow_d;
      urgent_q   <= (owed_d >= URG_LVL);
      case (state_q)
        IDLE: begin
          if (owed_d != '0) begin
            state_q   <= REQ;
            ref_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (accept) begin
            state_q    <= RFC;
            rfc_q      <= RFC_LOAD;
            ref_req_q  <= 1'b0;
            ref_busy_q <= 1'b1;
          end
        end
        RFC: begin
          if (rfc_q == '0) begin
            ref_busy_q <= 1'b0;
            if (owed_d != '0) begin
              state_q   <= REQ;
              ref_req_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            rfc_q <= rfc_q - RW'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          ref_req_q  <= 1'b0;
          ref_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign ref_bus.ref_req  = ref_req_q;
  assign ref_bus.ref_busy = ref_busy_q;
  assign ref_bus.urgent   = urgent_q;
  assign ref_bus.overflow = overflow_q;
  assign ref_bus.owed     = owed_q;

endmodule

// File: doc/refresh_scheduler.md
Name: refresh_scheduler

Overview:
Parametrised DDR3 refresh scheduler that replaces the single fixed-interval refresh comparator at the controller top level. It generates one refresh credit every tREFI, accumulates up to MAX_POSTPONE postponed refreshes, and requests them from the command state machine with a req/ack handshake. After each accepted refresh it holds a tRFC busy window and flags urgency and postponement overflow. It sits between the board clock domain and the command state machine's REF input.

Parameters:
TREFI_CYCLES, 1560, clk cycles per refresh interval (7.8 us at 200 MHz); must be >= 2.
TRFC_CYCLES, 32, clk cycles ref_busy stays high after an accepted refresh; must be >= 1.
MAX_POSTPONE, 8, maximum outstanding refresh credits (DDR3 limit 8); must be >= 1.
URGENT_THRESH, 6, owed count at or above which urgent asserts; must be 1..MAX_POSTPONE.

Ports:
clk  input  1  controller clock.
RESET_SM_button  input  1  asynchronous reset, active-high.
enable  input  1  allows interval counting; low = counter cleared and held.
ref_ack  input  1  state machine has issued the REF command this cycle.
ref_req  output  1  refresh owed and scheduler ready; level signal.
ref_busy  output  1  tRFC window active; the state machine must not issue ACT.
urgent  output  1  owed >= URGENT_THRESH; the state machine must preempt READ/WRITE.
owed  output  OW=$clog2(MAX_POSTPONE+1)  outstanding refresh credits.
overflow  output  1  sticky; a tick arrived with owed == MAX_POSTPONE.

Behaviour:
- Reset is asynchronous, active-high, on RESET_SM_button; the clock is clk. On reset: interval counter = 0, owed = 0, rfc counter = 0, state = IDLE. All outputs are 0, including overflow.
- Interval counter width is $clog2(TREFI_CYCLES).
  - While enable = 1 it counts 0..TREFI_CYCLES-1 and wraps.
  - tick = 1 for the single cycle in which count == TREFI_CYCLES-1.
  - While enable = 0 the counter is forced to 0, no ticks occur, and owed credits are still requested and served.
- Credit update, applied each cycle:
  - tick only: owed+1.
  - accepted ack only: owed-1.
  - tick and accepted ack together: owed unchanged.
  - tick with owed == MAX_POSTPONE and no accepted ack: owed holds at MAX_POSTPONE and overflow sets. overflow clears only on reset.
- State machine (IDLE, REQ, RFC):
  - IDLE: ref_req = 0. Moves to REQ on the cycle after owed becomes > 0 (registered).
  - REQ: ref_req = 1. ref_ack is accepted only in REQ. On acceptance: owed-1, go to RFC, load rfc counter with TRFC_CYCLES-1.
  - RFC: ref_busy = 1, ref_req = 0. rfc counter decrements. At 0, go to REQ if owed (after update) > 0, else IDLE.
  - ref_ack in IDLE or RFC is ignored: no owed change, no state change.
- Latency: tick to ref_req = 1 cycle. ack to ref_busy = 1 cycle. ref_busy stays high for exactly TRFC_CYCLES cycles.
- All outputs are registered. urgent is compared against the registered owed.
- A reset asserted mid-RFC aborts the window immediately; ref_busy drops asynchronously.
- Counters never wrap below 0 or above MAX_POSTPONE.

Decomposition:
- Shared package ddr3_timing_pkg holds:
  - default TREFI/TRFC cycle constants for 200 MHz;
  - MAX_POSTPONE = 8;
  - the refresh state enum {IDLE, REQ, RFC}.
- One natural sub-module: refresh_interval_timer (interval counter plus tick generation, with enable/clear). The credit counter and state machine remain in refresh_scheduler.

Test Plan (bench parameters TREFI_CYCLES=16, TRFC_CYCLES=4, MAX_POSTPONE=8, URGENT_THRESH=6):
1. Reset, enable=1, ack tied high → first ref_req at cycle 16 after reset release; ack accepted; ref_busy high for exactly 4 cycles; owed returns to 0; pattern repeats every 16 cycles.
2. enable=1, ack=0 for 6 intervals (96 cycles) → owed steps 1..6, urgent rises on the cycle owed=6; then ack held 1 → 6 refreshes accepted, spaced 5 cycles apart, owed reaches 0, urgent drops when owed=5.
3. ack=0 for 9 intervals → owed saturates at 8, overflow=1 at the 9th tick and stays 1 after owed drains; cleared only by RESET_SM_button.
4. Align ack acceptance with a tick (owed=1) → owed stays 1, state goes RFC then back to REQ after 4 cycles.
5. Assert RESET_SM_button for 1 cycle during the second RFC cycle (owed=3) → ref_busy, ref_req, owed, urgent and overflow go to 0 immediately; the next ref_req arrives 16 cycles after release.
6. enable=0 with owed=2 → no new ticks for 100 cycles; both credits are still served via ack; re-enable → the next tick occurs 16 cycles later; ack pulses during IDLE or RFC change nothing.
